fetch_unit: RTL

- Instruction fetch stage directly upstream of the controller/datapath in the ARM (LEGv8) core.
- Owns the PC and issues word requests to instruction memory over a req/ack + rvalid handshake.
- Buffers returned words with their PC in a small FIFO and presents them to decode with a valid/ready handshake; decode feeds instr[31:21] to the controller.
- Accepts taken-branch redirects from the datapath and squashes stale fetches.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
package fetch_pkg;
  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between fetch and decode: power-of-2 ring with
// flush, simultaneous push/pop, and a zeroed head while empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          valid,
  output entry_t        head
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;
  entry_t        mem_q [DEPTH];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && (count_q != '0) && !flush;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the head is forced to zero while empty,
  // so stale words can never reach decode.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign valid = (count_q != '0);
  assign head  = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 fetch stage: owns the PC, issues one outstanding imem request at a time,
// buffers returned words and squashes fetches made stale by a taken branch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int           N        = PC_W,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int           DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [N-1:0]       imem_addr,
  input  logic               imem_ack,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [N-1:0]       redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [N-1:0]       instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t state_q, state_d;
  logic [N-1:0] fetch_pc_q, fetch_pc_d;
  logic         squash_q, squash_d;
  logic         imem_req_q, imem_req_d;
  logic [N-1:0] imem_addr_q, imem_addr_d;

  logic          push;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic          issue_ok;

  // A request in flight always owns a FIFO slot, so its response can never be refused.
  always_comb begin
    occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, (state_q != IDLE)};
    issue_ok  = occupancy < (CW+1)'(DEPTH);
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    squash_d    = squash_q;
    imem_addr_d = imem_addr_q;
    push        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!redirect && issue_ok) begin
          state_d     = REQ;
          imem_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (imem_ack) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d  = IDLE;
          squash_d = 1'b0;
          if (!squash_q && !redirect) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + N'(PC_STEP);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A redirect that coincides with the response drops that word directly,
    // so only a still-pending transaction needs the squash flag.
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      if ((state_q == REQ) || (state_q == WAIT && !imem_rvalid)) squash_d = 1'b1;
    end

    imem_req_d = (state_d == REQ);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      squash_q    <= 1'b0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      squash_q    <= squash_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  always_comb begin
    push_entry.pc    = PC_W'(fetch_pc_q);
    push_entry.instr = imem_rdata;
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (instr_ready),
    .count     (fifo_count),
    .valid     (instr_valid),
    .head      (head)
  );

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign instr     = head.instr;
  assign instr_pc  = N'(head.pc);

endmodule
